// File: rtl/cva6_axi_sram_responder.sv
// AXI4 responder backed by a flop word array, with independent AW/W/B and AR/R state machines.
// Define CVA6_AXI_SRAM_RESP_USER_EN to keep a per-word user array returned on R.
module cva6_axi_sram_responder #(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiUserWidth = 32,
  parameter int unsigned MemWords     = 1024,
  parameter logic [63:0] BaseAddr     = 64'h8000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [AxiIdWidth-1:0]   aw_id_i,
  input  logic [AxiAddrWidth-1:0] aw_addr_i,
  input  logic [7:0]              aw_len_i,
  input  logic [2:0]              aw_size_i,
  input  logic [1:0]              aw_burst_i,
  input  logic [5:0]              aw_atop_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [AxiDataWidth-1:0] w_data_i,
  input  logic [7:0]              w_strb_i,
  input  logic                    w_last_i,
  input  logic [AxiUserWidth-1:0] w_user_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [AxiIdWidth-1:0]   b_id_o,
  output logic [1:0]              b_resp_o,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic [AxiUserWidth-1:0] r_user_o
);
  localparam int unsigned IdxW = $clog2(MemWords);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [AxiAddrWidth-1:0] Base = AxiAddrWidth'(BaseAddr);
  localparam logic [AxiAddrWidth-1:0] Span = AxiAddrWidth'(MemWords) << 3;

  typedef struct packed {
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic [1:0] addr_resp(input logic [AxiAddrWidth-1:0] addr,
                                           input logic [2:0] size, input logic [1:0] burst);
    if (addr < Base || (addr - Base) >= Span) return RespDecerr;
    if (size > 3'd3 || !(burst == BurstFixed || burst == BurstIncr)) return RespSlverr;
    return RespOkay;
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [AxiAddrWidth-1:0] addr);
    return IdxW'((addr - Base) >> 3);
  endfunction

  function automatic logic [AxiAddrWidth-1:0] next_addr(input logic [AxiAddrWidth-1:0] addr,
                                                        input logic [2:0] size, input logic [1:0] burst);
    return (burst == BurstIncr) ? addr + (AxiAddrWidth'(1) << size) : addr;
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [AxiDataWidth-1:0] mem [MemWords];

  // ---------------- write channel ----------------
  w_state_e                w_state_q, w_state_d;
  burst_t                  aw_q, aw_d;
  logic                    atop_q, atop_d;
  logic [7:0]              w_cnt_q, w_cnt_d;
  logic [1:0]              w_acc_q, w_acc_d;
  logic [AxiIdWidth-1:0]   w_id_q, w_id_d;
  logic                    aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
  logic [AxiIdWidth-1:0]   b_id_q, b_id_d;
  logic [1:0]              b_resp_q, b_resp_d;
  logic [1:0]              w_beat_resp;
  logic                    mem_we;
  logic [IdxW-1:0]         w_idx;

  assign w_idx = word_idx(aw_q.addr);

  always_comb begin : w_fsm
    w_state_d   = w_state_q;
    aw_d        = aw_q;
    atop_d      = atop_q;
    w_cnt_d     = w_cnt_q;
    w_acc_d     = w_acc_q;
    w_id_d      = w_id_q;
    b_valid_d   = b_valid_q;
    b_id_d      = b_id_q;
    b_resp_d    = b_resp_q;
    w_beat_resp = RespOkay;
    mem_we      = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (aw_valid_i && aw_ready_o) begin
        aw_d      = '{addr: aw_addr_i, len: aw_len_i, size: aw_size_i, burst: aw_burst_i};
        atop_d    = |aw_atop_i;
        w_id_d    = aw_id_i;
        w_cnt_d   = 8'd0;
        w_acc_d   = RespOkay;
        w_state_d = W_DATA;
      end
      W_DATA: if (w_valid_i && w_ready_o) begin
        // Address/ATOP errors suppress the write; a w_last mismatch only flags the response.
        w_beat_resp = atop_q ? RespSlverr : addr_resp(aw_q.addr, aw_q.size, aw_q.burst);
        mem_we      = (w_beat_resp == RespOkay);
        if (w_last_i != (w_cnt_q == aw_q.len)) w_beat_resp = worst(w_beat_resp, RespSlverr);
        w_acc_d     = worst(w_acc_q, w_beat_resp);
        aw_d.addr   = next_addr(aw_q.addr, aw_q.size, aw_q.burst);
        w_cnt_d     = w_cnt_q + 8'd1;
        if (w_cnt_q == aw_q.len) begin
          w_state_d = W_RESP;
          b_valid_d = 1'b1;
          b_id_d    = w_id_q;
          b_resp_d  = w_acc_d;
        end
      end
      W_RESP: if (b_ready_i) begin
        b_valid_d = 1'b0;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE);
    w_ready_d  = (w_state_d == W_DATA);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : w_regs
    if (rst_i) begin
      w_state_q  <= W_IDLE;
      aw_q       <= '0;
      atop_q     <= 1'b0;
      w_cnt_q    <= 8'd0;
      w_acc_q    <= RespOkay;
      w_id_q     <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= RespOkay;
    end else begin
      w_state_q  <= w_state_d;
      aw_q       <= aw_d;
      atop_q     <= atop_d;
      w_cnt_q    <= w_cnt_d;
      w_acc_q    <= w_acc_d;
      w_id_q     <= w_id_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_id_q     <= b_id_d;
      b_resp_q   <= b_resp_d;
    end
  end

  always_ff @(posedge clk_i) begin : mem_write
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (w_strb_i[b]) mem[w_idx][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  assign aw_ready_o = aw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = b_valid_q;
  assign b_id_o     = b_id_q;
  assign b_resp_o   = b_resp_q;

  // ---------------- read channel ----------------
  r_state_e                r_state_q, r_state_d;
  burst_t                  ar_q, ar_d;
  logic [7:0]              r_cnt_q, r_cnt_d;
  logic                    ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic [AxiIdWidth-1:0]   r_id_q, r_id_d;
  logic [AxiDataWidth-1:0] r_data_q, r_data_d;
  logic [1:0]              r_resp_q, r_resp_d;
  logic                    r_load;
  logic [AxiAddrWidth-1:0] ld_addr;
  logic [2:0]              ld_size;
  logic [1:0]              ld_burst, ld_resp;
  logic [AxiDataWidth-1:0] ld_data;

  // Beat being loaded: the AR request when idle, else the successor of the current beat.
  always_comb begin : r_lookup
    if (r_state_q == R_IDLE) begin
      ld_addr  = ar_addr_i;
      ld_size  = ar_size_i;
      ld_burst = ar_burst_i;
    end else begin
      ld_addr  = next_addr(ar_q.addr, ar_q.size, ar_q.burst);
      ld_size  = ar_q.size;
      ld_burst = ar_q.burst;
    end
    ld_resp = addr_resp(ld_addr, ld_size, ld_burst);
    ld_data = (ld_resp == RespOkay) ? mem[word_idx(ld_addr)] : '0;
  end

  always_comb begin : r_fsm
    r_state_d = r_state_q;
    ar_d      = ar_q;
    r_cnt_d   = r_cnt_q;
    r_valid_d = r_valid_q;
    r_last_d  = r_last_q;
    r_id_d    = r_id_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_load    = 1'b0;
    unique case (r_state_q)
      R_IDLE: if (ar_valid_i && ar_ready_o) begin
        ar_d      = '{addr: ar_addr_i, len: ar_len_i, size: ar_size_i, burst: ar_burst_i};
        r_cnt_d   = 8'd0;
        r_id_d    = ar_id_i;
        r_last_d  = (ar_len_i == 8'd0);
        r_valid_d = 1'b1;
        r_load    = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: if (r_valid_o && r_ready_i) begin
        if (r_cnt_q == ar_q.len) begin
          r_valid_d = 1'b0;
          r_last_d  = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          ar_d.addr = ld_addr;
          r_cnt_d   = r_cnt_q + 8'd1;
          r_last_d  = ((r_cnt_q + 8'd1) == ar_q.len);
          r_load    = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load) begin
      r_data_d = ld_data;
      r_resp_d = ld_resp;
    end
    ar_ready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : r_regs
    if (rst_i) begin
      r_state_q  <= R_IDLE;
      ar_q       <= '0;
      r_cnt_q    <= 8'd0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RespOkay;
    end else begin
      r_state_q  <= r_state_d;
      ar_q       <= ar_d;
      r_cnt_q    <= r_cnt_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_last_q   <= r_last_d;
      r_id_q     <= r_id_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  assign ar_ready_o = ar_ready_q;
  assign r_valid_o  = r_valid_q;
  assign r_last_o   = r_last_q;
  assign r_id_o     = r_id_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;

`ifdef CVA6_AXI_SRAM_RESP_USER_EN
  logic [AxiUserWidth-1:0] umem [MemWords];
  logic [AxiUserWidth-1:0] r_user_q;

  always_ff @(posedge clk_i) begin : umem_write
    if (mem_we && |w_strb_i) umem[w_idx] <= w_user_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : r_user_reg
    if (rst_i) r_user_q <= '0;
    else if (r_load) r_user_q <= (ld_resp == RespOkay) ? umem[word_idx(ld_addr)] : '0;
  end

  assign r_user_o = r_user_q;
`else
  logic unused_user;
  assign unused_user = ^w_user_i;
  assign r_user_o    = '0;
`endif

endmodule

// File: tb/tb_cva6_axi_sram_responder.sv
// Table-driven bench for cva6_axi_sram_responder with a read-beat scoreboard and reset corner cases.
module tb_cva6_axi_sram_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        aw_valid_i, aw_ready_o;
  logic [3:0]  aw_id_i;
  logic [63:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic [2:0]  aw_size_i;
  logic [1:0]  aw_burst_i;
  logic [5:0]  aw_atop_i;
  logic        w_valid_i, w_ready_o;
  logic [63:0] w_data_i;
  logic [7:0]  w_strb_i;
  logic        w_last_i;
  logic [31:0] w_user_i;
  logic        b_valid_o, b_ready_i;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i, ar_ready_o;
  logic [3:0]  ar_id_i;
  logic [63:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [2:0]  ar_size_i;
  logic [1:0]  ar_burst_i;
  logic        r_valid_o, r_ready_i;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic [31:0] r_user_o;

  cva6_axi_sram_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i), .aw_atop_i(aw_atop_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_last_i(w_last_i), .w_user_i(w_user_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o), .r_user_o(r_user_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    bit          wr;
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
    logic [63:0] data;
    logic [7:0]  strb;
    bit          early;
    int          mode;
    logic [1:0]  exp_resp;
    bit          chk_data;
    logic [63:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  int          ncmp = 0;
  int          nfail = 0;
  beat_t       sbq[$];
  logic [63:0] mdl [1024];
  vec_t        vecs[15];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [1:0] m_resp(input logic [63:0] a, input logic [2:0] sz, input logic [1:0] bu);
    if (a < BASE || a >= BASE + 64'd8192) return 2'b11;
    if (sz > 3'd3 || bu > 2'b01) return 2'b10;
    return 2'b00;
  endfunction

  task automatic do_write(input vec_t v);
    logic [63:0] a, d;
    logic [1:0]  r;
    int          n, idx;
    a = v.addr;
    aw_valid_i = 1'b1; aw_id_i = v.id; aw_addr_i = v.addr; aw_len_i = v.len;
    aw_size_i = v.size; aw_burst_i = v.burst; aw_atop_i = v.atop;
    n = 0;
    while (!aw_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (!aw_ready_o) chk({v.name, "_aw_timeout"}, 64'd0, 64'd1);
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0; aw_atop_i = 6'd0;
    for (int i = 0; i <= int'(v.len); i++) begin
      d = v.data + 64'(i);
      w_valid_i = 1'b1; w_data_i = d; w_strb_i = v.strb; w_user_i = 32'(i);
      w_last_i = (i == int'(v.len)) || (v.early && i == 0);
      n = 0;
      while (!w_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
      if (!w_ready_o) chk({v.name, "_w_timeout"}, 64'd0, 64'd1);
      @(posedge clk_i); #1;
      r = (v.atop != 6'd0) ? 2'b10 : m_resp(a, v.size, v.burst);
      if (r == 2'b00) begin
        idx = int'((a - BASE) >> 3);
        for (int b = 0; b < 8; b++) if (v.strb[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
      end
      if (v.burst == 2'b01) a = a + (64'd1 << v.size);
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    n = 0;
    while (!b_valid_o && n < 50) begin @(posedge clk_i); #1; n++; end
    chk({v.name, "_b_delay"}, 64'(n), 64'd0);
    chk({v.name, "_b_resp"}, 64'(b_resp_o), 64'(v.exp_resp));
    chk({v.name, "_b_id"}, 64'(b_id_o), 64'(v.id));
    b_ready_i = 1'b1;
    @(posedge clk_i); #1;
    b_ready_i = 1'b0;
    chk({v.name, "_b_drop"}, 64'(b_valid_o), 64'd0);
    chk({v.name, "_aw_ready_back"}, 64'(aw_ready_o), 64'd1);
  endtask

  task automatic do_read(input vec_t v);
    logic [63:0] a;
    logic [1:0]  r;
    int          n, beats, cyc, idx;
    bit          stalled;
    beat_t       e, got, snap;
    a = v.addr;
    for (int i = 0; i <= int'(v.len); i++) begin
      r = m_resp(a, v.size, v.burst);
      e.data = 64'd0;
      if (r == 2'b00) begin idx = int'((a - BASE) >> 3); e.data = mdl[idx]; end
      e.resp = r; e.last = (i == int'(v.len)); e.id = v.id;
      sbq.push_back(e);
      if (v.burst == 2'b01) a = a + (64'd1 << v.size);
    end
    ar_valid_i = 1'b1; ar_id_i = v.id; ar_addr_i = v.addr; ar_len_i = v.len;
    ar_size_i = v.size; ar_burst_i = v.burst;
    n = 0;
    while (!ar_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (!ar_ready_o) chk({v.name, "_ar_timeout"}, 64'd0, 64'd1);
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    beats = 0; cyc = 0; stalled = 1'b0; snap = '0;
    while (beats <= int'(v.len) && cyc < 100) begin
      r_ready_i = (v.mode == 0) ? 1'b1 : (cyc % 2 == 0);
      got = '{data: r_data_o, resp: r_resp_o, last: r_last_o, id: r_id_o};
      if (stalled) begin
        chk({v.name, "_stall_valid"}, 64'(r_valid_o), 64'd1);
        chk({v.name, "_stall_data"}, got.data, snap.data);
        chk({v.name, "_stall_meta"}, 64'({got.resp, got.last, got.id}), 64'({snap.resp, snap.last, snap.id}));
      end
      if (r_valid_o) chk({v.name, "_ar_ready_busy"}, 64'(ar_ready_o), 64'd0);
      if (r_valid_o && r_ready_i) begin
        if (sbq.size() == 0) chk({v.name, "_sb_underflow"}, 64'd1, 64'd0);
        else begin
          e = sbq.pop_front();
          chk({v.name, "_r_data"}, got.data, e.data);
          chk({v.name, "_r_meta"}, 64'({got.resp, got.last, got.id}), 64'({e.resp, e.last, e.id}));
          if (beats == 0) begin
            chk({v.name, "_r_resp0"}, 64'(got.resp), 64'(v.exp_resp));
            if (v.chk_data) chk({v.name, "_r_data0"}, got.data, v.exp_data);
          end
        end
        beats++;
      end
      stalled = r_valid_o && !r_ready_i;
      snap = got;
      @(posedge clk_i); #1;
      cyc++;
    end
    r_ready_i = 1'b0;
    chk({v.name, "_r_beats"}, 64'(beats), 64'(int'(v.len) + 1));
    chk({v.name, "_ar_ready_back"}, 64'(ar_ready_o), 64'd1);
    sbq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hs;
    vec_t rv;
    vecs[0]  = '{"wr_burst",   1'b1, 4'd1, 64'h8000_0000, 8'd3, 3'd3, 2'b01, 6'h00, 64'h0101_0000_0000_0000, 8'hFF, 1'b0, 0, 2'b00, 1'b0, 64'd0};
    vecs[1]  = '{"wr_single",  1'b1, 4'd5, 64'h8000_0010, 8'd0, 3'd3, 2'b01, 6'h00, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 0, 2'b00, 1'b0, 64'd0};
    vecs[2]  = '{"rd_single",  1'b0, 4'd6, 64'h8000_0010, 8'd0, 3'd3, 2'b01, 6'h00, 64'd0, 8'h00, 1'b0, 0, 2'b00, 1'b1, 64'h1122_3344_5566_7788};
    vecs[3]  = '{"wr_partial", 1'b1, 4'd2, 64'h8000_0010, 8'd0, 3'd3, 2'b01, 6'h00, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b0, 0, 2'b00, 1'b0, 64'd0};
    vecs[4]  = '{"rd_partial", 1'b0, 4'd7, 64'h8000_0010, 8'd0, 3'd3, 2'b01, 6'h00, 64'd0, 8'h00, 1'b0, 0, 2'b00, 1'b1, 64'h1122_3344_BBBB_BBBB};
    vecs[5]  = '{"rd_incr4",   1'b0, 4'd8, 64'h8000_0000, 8'd3, 3'd3, 2'b01, 6'h00, 64'd0, 8'h00, 1'b0, 1, 2'b00, 1'b1, 64'h0101_0000_0000_0000};
    vecs[6]  = '{"wr_low",     1'b1, 4'd9, 64'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 6'h00, 64'hDEAD_BEEF_0000_0000, 8'hFF, 1'b0, 0, 2'b11, 1'b0, 64'd0};
    vecs[7]  = '{"rd_low",     1'b0, 4'd9, 64'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 6'h00, 64'd0, 8'h00, 1'b0, 0, 2'b11, 1'b1, 64'd0};
    vecs[8]  = '{"rd_high",    1'b0, 4'hA, 64'h8000_2000, 8'd0, 3'd3, 2'b01, 6'h00, 64'd0, 8'h00, 1'b0, 0, 2'b11, 1'b1, 64'd0};
    vecs[9]  = '{"wr_early",   1'b1, 4'hB, 64'h8000_0020, 8'd1, 3'd3, 2'b01, 6'h00, 64'h5555_0000_0000_0000, 8'hFF, 1'b1, 0, 2'b10, 1'b0, 64'd0};
    vecs[10] = '{"wr_atop",    1'b1, 4'hC, 64'h8000_0008, 8'd0, 3'd3, 2'b01, 6'h20, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 1'b0, 0, 2'b10, 1'b0, 64'd0};
    vecs[11] = '{"rd_atop",    1'b0, 4'hD, 64'h8000_0008, 8'd0, 3'd3, 2'b01, 6'h00, 64'd0, 8'h00, 1'b0, 0, 2'b00, 1'b1, 64'h0101_0000_0000_0001};
    vecs[12] = '{"wr_fixed",   1'b1, 4'hE, 64'h8000_0030, 8'd1, 3'd3, 2'b00, 6'h00, 64'h0000_0000_CAFE_0000, 8'hFF, 1'b0, 0, 2'b00, 1'b0, 64'd0};
    vecs[13] = '{"rd_fixed",   1'b0, 4'hF, 64'h8000_0030, 8'd2, 3'd3, 2'b00, 6'h00, 64'd0, 8'h00, 1'b0, 0, 2'b00, 1'b1, 64'h0000_0000_CAFE_0001};
    vecs[14] = '{"rd_wrap",    1'b0, 4'd4, 64'h8000_0000, 8'd1, 3'd3, 2'b10, 6'h00, 64'd0, 8'h00, 1'b0, 0, 2'b10, 1'b1, 64'd0};

    rst_i = 1'b1;
    aw_valid_i = 1'b0; aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0; aw_burst_i = '0; aw_atop_i = '0;
    w_valid_i = 1'b0; w_data_i = '0; w_strb_i = '0; w_last_i = 1'b0; w_user_i = '0;
    b_ready_i = 1'b0;
    ar_valid_i = 1'b0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0; ar_burst_i = '0;
    r_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_readies", 64'({aw_ready_o, w_ready_o, ar_ready_o}), 64'd0);
    chk("rst_valids", 64'({b_valid_o, r_valid_o, r_last_o}), 64'd0);
    chk("rst_ids_resps", 64'({b_id_o, b_resp_o, r_id_o, r_resp_o}), 64'd0);
    chk("rst_r_data", r_data_o, 64'd0);
    chk("rst_r_user", 64'(r_user_o), 64'd0);
    rst_i = 1'b0;
    chk("rel_aw_ready_low", 64'(aw_ready_o), 64'd0);
    @(posedge clk_i); #1;
    chk("rel_aw_ready", 64'(aw_ready_o), 64'd1);
    chk("rel_ar_ready", 64'(ar_ready_o), 64'd1);

    // W data offered without AW must stall
    w_valid_i = 1'b1; w_data_i = 64'hFFFF_FFFF_FFFF_FFFF; w_strb_i = 8'hFF; w_last_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("w_before_aw", 64'(w_ready_o), 64'd0);
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) do_write(vecs[i]);
      else do_read(vecs[i]);
    end

    // Reset in the middle of an 8-beat read, on beat 2
    ar_valid_i = 1'b1; ar_id_i = 4'd3; ar_addr_i = BASE; ar_len_i = 8'd7; ar_size_i = 3'd3; ar_burst_i = 2'b01;
    n = 0;
    while (!ar_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    r_ready_i = 1'b1;
    n = 0; hs = 0;
    while (hs < 2 && n < 50) begin
      if (r_valid_o) hs++;
      @(posedge clk_i); #1;
      n++;
    end
    chk("mid_pre_valid", 64'(r_valid_o), 64'd1);
    chk("mid_pre_data", r_data_o, mdl[2]);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(r_valid_o), 64'd0);
    chk("mid_rst_ar_ready", 64'(ar_ready_o), 64'd0);
    r_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("mid_rel_ar_low", 64'(ar_ready_o), 64'd0);
    @(posedge clk_i); #1;
    chk("mid_rel_ar_ready", 64'(ar_ready_o), 64'd1);
    rv = vecs[4];
    rv.name = "rd_after_rst";
    do_read(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/cva6_axi_sram_responder.md
Name: cva6_axi_sram_responder

Overview:
- AXI4 subordinate (responder) SRAM for the far end of the CVA6 AXI master port.
- Sized to the cv32a65x bus: 4-bit ID, 64-bit address, 64-bit data, 32-bit user.
- Serves INCR/FIXED bursts from a flop-based word array with independent read and write channel state machines.
- Used as the cached-region backing store in block-level and subsystem benches and small FPGA builds.

Parameters:
- AxiIdWidth, 4, ID width on all channels.
- AxiAddrWidth, 64, address width.
- AxiDataWidth, 64, data width; fixed 8-byte lanes.
- AxiUserWidth, 32, W/R user width.
- MemWords, 1024, 64-bit words of storage; power of two.
- BaseAddr, 64'h8000_0000, byte address of word 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- aw_valid_i/aw_ready_o  in/out  1/1  AW handshake
- aw_id_i  in  AxiIdWidth  write ID
- aw_addr_i  in  AxiAddrWidth  write start address
- aw_len_i  in  8  beats-1
- aw_size_i  in  3  log2 bytes per beat
- aw_burst_i  in  2  burst type
- aw_atop_i  in  6  atomic op
- w_valid_i/w_ready_o  in/out  1/1  W handshake
- w_data_i  in  AxiDataWidth  write data
- w_strb_i  in  8  byte strobes
- w_last_i  in  1  last beat
- w_user_i  in  AxiUserWidth  write user
- b_valid_o/b_ready_i  out/in  1/1  B handshake
- b_id_o  out  AxiIdWidth  echoed ID
- b_resp_o  out  2  write response
- ar_valid_i/ar_ready_o  in/out  1/1  AR handshake
- ar_id_i  in  AxiIdWidth  read ID
- ar_addr_i  in  AxiAddrWidth  read start address
- ar_len_i  in  8  beats-1
- ar_size_i  in  3  log2 bytes per beat
- ar_burst_i  in  2  burst type
- r_valid_o/r_ready_i  out/in  1/1  R handshake
- r_id_o  out  AxiIdWidth  read ID
- r_data_o  out  AxiDataWidth  read data
- r_resp_o  out  2  read response
- r_last_o  out  1  last beat
- r_user_o  out  AxiUserWidth  read user

Behaviour:
- Reset (rst_i high, async) values:
  - all *_ready_o, b_valid_o, r_valid_o, r_last_o = 0.
  - b_id_o, b_resp_o, r_id_o, r_data_o, r_resp_o, r_user_o = 0.
  - Both FSMs IDLE. Memory array is not reset.
- All outputs are registered. aw_ready_o and ar_ready_o rise the first cycle after reset release.
- Word index = (addr - BaseAddr) >> 3. Out of range (addr < BaseAddr or index >= MemWords) gives DECERR (2'b11) for that beat: write dropped, read data 0.
- Beat address update:
  - INCR: addr += 1 << size.
  - FIXED: addr unchanged.
  - WRAP, or size > 3: SLVERR (2'b10) on every beat. Protocol still completes; no memory write.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: aw_ready_o=1. On AW handshake, latch id/addr/len/size/burst, go to W_DATA; aw_ready_o drops next cycle.
  - W_DATA: w_ready_o=1. One beat per W handshake. Each byte with w_strb_i=1 is written at the clock edge.
  - Termination uses the beat count (len+1), not w_last_i. If w_last_i disagrees with the count on any beat, resp = SLVERR.
  - W_RESP: b_valid_o=1 the cycle after the final W handshake. Holds until b_ready_i; then W_IDLE.
  - b_resp_o is the worst response over all beats (DECERR > SLVERR > OKAY).
  - aw_atop_i != 0: all writes suppressed, b_resp_o=SLVERR, no R beat. This config has RVA=0, so ATOPs are unexpected.
  - W beats arriving before AW stall (w_ready_o=0).
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ar_ready_o=1. On AR handshake, latch fields; first r_valid_o one cycle later.
  - R_DATA: on each r_ready_i&&r_valid_o, load the next beat the same edge, giving back-to-back beats at 1/cycle.
  - r_last_o=1 on beat len. After the last handshake, return to R_IDLE with ar_ready_o=1 next cycle.
  - r_data_o, r_resp_o, r_id_o, r_last_o are held stable while r_valid_o && !r_ready_i.
- Read and write channels are independent. When a read beat loads a word in the same cycle a W beat writes it, the read returns the old data.
- Exactly one outstanding transaction per channel; no reordering.

Optional Feature:
- Macro: CVA6_AXI_SRAM_RESP_USER_EN.
- Defined: a parallel user array of MemWords x AxiUserWidth is written with w_user_i when any strobe is set. r_user_o returns the stored user word (0 on error beats).
- Undefined: no user array, w_user_i ignored, r_user_o tied 0.

Test Plan:
- Reset, then single write: addr 0x8000_0010, len 0, data 0x1122334455667788, strb 0xFF -> b_valid_o 1 cycle after W, b_resp_o=OKAY, b_id_o echoed. Read same address -> r_data_o=0x1122334455667788, r_last_o=1, r_resp_o=OKAY.
- Partial strobe: strb 0x0F with data 0xAAAAAAAA_BBBBBBBB over the prior word -> readback 0x11223344_BBBBBBBB.
- INCR read len=3 from 0x8000_0000 with r_ready_i toggling 1,0,1,0 -> 4 beats, data stable across stalls, r_last_o only on beat 3, ar_ready_o low until the final handshake.
- Out of range: write to 0x7FFF_FFF8 -> b_resp_o=DECERR, memory unchanged. Read at BaseAddr+8*MemWords -> r_resp_o=DECERR, r_data_o=0.
- Protocol errors: w_last_i early on beat 0 of a len=1 burst -> 2 beats accepted, b_resp_o=SLVERR. aw_atop_i=6'h20 -> b_resp_o=SLVERR, no write.
- Assert rst_i mid-burst (beat 2 of len=7 read) -> r_valid_o=0 immediately. After release, ar_ready_o=1 next cycle and a new read completes normally.
